// File: rtl/sd_cmd_pkg.sv
// Shared constants and types for the SD command path (frame build and response receive).
package sd_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CRC  = 2'd1,
    ST_SEND = 2'd2
  } cmd_state_e;

  localparam logic [6:0] CRC7_POLY = 7'h09;
  localparam int         FRAME_LEN = 48;
  localparam int         HDR_LEN   = 40;
  localparam int         BYTE_CNT  = 6;
  localparam logic       START_BIT = 1'b0;
  localparam logic       TX_BIT    = 1'b1;
  localparam logic       END_BIT   = 1'b1;

  // Byte k of a frame, k=0 being the most significant byte on the wire.
  function automatic logic [7:0] frame_byte(input logic [FRAME_LEN-1:0] f, input logic [2:0] k);
    logic [7:0] b;
    case (k)
      3'd0:    b = f[47:40];
      3'd1:    b = f[39:32];
      3'd2:    b = f[31:24];
      3'd3:    b = f[23:16];
      3'd4:    b = f[15:8];
      3'd5:    b = f[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/crc7_serial.sv
// Bit-serial CRC7 (x^7+x^3+1), MSB first, seed 0. Caller gates clear/shift_en with its enable.
module crc7_serial
  import sd_cmd_pkg::*;
(
  input  logic       sd_clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       shift_en,
  input  logic       data_in,
  output logic [6:0] crc
);

  logic [6:0] r_crc;
  logic       w_fb;

  assign w_fb = data_in ^ r_crc[6];
  assign crc  = r_crc;

  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset)         r_crc <= '0;
    else if (clear)    r_crc <= '0;
    else if (shift_en) r_crc <= {r_crc[5:0], 1'b0} ^ (w_fb ? CRC7_POLY : 7'h00);
  end

endmodule

// File: rtl/cmd_frame_builder.sv
// Builds the 48-bit SD command frame (start, tx, index, arg, CRC7, end) and hands it
// byte by byte to the parallel-to-serial stage over a valid/ready handshake.
module cmd_frame_builder
  import sd_cmd_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         sd_clock,
  input  logic         reset,
  input  logic         enable,
  input  logic         cmd_valid,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  output logic         cmd_ready,
  output logic [n-1:0] parallel,
  output logic         byte_valid,
  input  logic         byte_ready,
  output logic         busy,
  output logic         done
);

  cmd_state_e           r_state, w_state_nxt;
  logic [HDR_LEN-1:0]   r_hdr;
  logic [5:0]           r_bit_cnt;
  logic [2:0]           r_byte_cnt;
  logic [n-1:0]         r_parallel;
  logic                 r_byte_valid;
  logic                 r_done;
  logic [6:0]           w_crc;
  logic [FRAME_LEN-1:0] w_frame;
  logic [5:0]           w_bit_idx;
  logic                 w_accept, w_shift, w_crc_done, w_xfer, w_last;

  assign cmd_ready  = (r_state == ST_IDLE) && enable;
  assign busy       = (r_state != ST_IDLE);
  assign parallel   = r_parallel;
  assign byte_valid = r_byte_valid;
  assign done       = r_done;

  assign w_accept   = cmd_ready && cmd_valid;
  assign w_shift    = enable && (r_state == ST_CRC) && (r_bit_cnt != 6'(HDR_LEN));
  assign w_crc_done = enable && (r_state == ST_CRC) && (r_bit_cnt == 6'(HDR_LEN));
  assign w_xfer     = enable && (r_state == ST_SEND) && byte_ready;
  assign w_last     = (r_byte_cnt == 3'(BYTE_CNT - 1));
  assign w_bit_idx  = 6'(HDR_LEN - 1) - r_bit_cnt;
  assign w_frame    = {r_hdr, w_crc, END_BIT};

  crc7_serial u_crc (
    .sd_clock (sd_clock),
    .reset    (reset),
    .clear    (w_accept),
    .shift_en (w_shift),
    .data_in  (r_hdr[w_bit_idx]),
    .crc      (w_crc)
  );

  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)          w_state_nxt = ST_CRC;
      ST_CRC:  if (w_crc_done)        w_state_nxt = ST_SEND;
      ST_SEND: if (w_xfer && w_last)  w_state_nxt = ST_IDLE;
      default:                        w_state_nxt = ST_IDLE;
    endcase
  end

  // The bit counter runs 0..39 while shifting and parks at 40 for the one cycle
  // that loads byte 0, which is what makes first byte_valid land 41 cycles out.
  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      r_hdr        <= '0;
      r_bit_cnt    <= '0;
      r_byte_cnt   <= '0;
      r_parallel   <= '0;
      r_byte_valid <= 1'b0;
      r_done       <= 1'b0;
    end else if (enable) begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_hdr      <= {START_BIT, TX_BIT, cmd_index, cmd_arg};
          r_bit_cnt  <= '0;
          r_byte_cnt <= '0;
        end
        ST_CRC: if (w_shift) begin
          r_bit_cnt <= r_bit_cnt + 6'd1;
        end else begin
          r_byte_cnt   <= '0;
          r_byte_valid <= 1'b1;
          r_parallel   <= n'(frame_byte(w_frame, 3'd0));
        end
        ST_SEND: if (byte_ready) begin
          if (w_last) begin
            r_byte_valid <= 1'b0;
            r_parallel   <= '0;
            r_done       <= 1'b1;
          end else begin
            r_byte_cnt <= r_byte_cnt + 3'd1;
            r_parallel <= n'(frame_byte(w_frame, r_byte_cnt + 3'd1));
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_frame_builder.sv
// Scoreboard bench for cmd_frame_builder: expected bytes queued at issue time, a monitor
// pops and compares on every byte handshake; CRC reference is polynomial long division.
module tb_cmd_frame_builder;

  logic        sd_clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [5:0]  cmd_index = '0;
  logic [31:0] cmd_arg = '0;
  logic        byte_ready = 1'b0;
  logic        cmd_ready, byte_valid, busy, done;
  logic [7:0]  parallel;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_seen = 0;
  int last_done_cyc = -1;
  int rdy_mode = 0;
  logic [7:0] exp_q[$];

  cmd_frame_builder #(.n(8)) dut (
    .sd_clock   (sd_clock),
    .reset      (reset),
    .enable     (enable),
    .cmd_valid  (cmd_valid),
    .cmd_index  (cmd_index),
    .cmd_arg    (cmd_arg),
    .cmd_ready  (cmd_ready),
    .parallel   (parallel),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 sd_clock = ~sd_clock;
  always @(posedge sd_clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Remainder of header*x^7 divided by x^7+x^3+1, done as long division.
  function automatic logic [47:0] model_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] hdr;
    logic [46:0] rem;
    hdr = {2'b01, idx, arg};
    rem = {hdr, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (rem[i]) rem = rem ^ (47'h89 << (i - 7));
    return {hdr, rem[6:0], 1'b1};
  endfunction

  task automatic push_frame(input logic [47:0] f);
    for (int k = 0; k < 6; k++) exp_q.push_back(f[47 - 8*k -: 8]);
  endtask

  task automatic push_bytes(input logic [47:0] b);
    push_frame(b);
  endtask

  // Monitor: byte compare on handshake, stability while held, done pulse width.
  logic [7:0] prev_par = '0;
  logic prev_hold = 1'b0, prev_done = 1'b0, prev_en = 1'b0;
  always @(negedge sd_clock) begin
    if (reset) begin
      prev_hold = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (done) begin
        chk("done_pulse_width", prev_done && prev_en, 1'b0);
        if (!prev_done) begin
          done_seen++;
          last_done_cyc = cyc;
        end
      end
      if (prev_hold && byte_valid) chk("parallel_stable", parallel, prev_par);
      if (byte_valid && enable && byte_ready) begin
        if (exp_q.size() == 0) chk("unexpected_byte", parallel, 9'h100);
        else chk("frame_byte", parallel, exp_q.pop_front());
      end
      prev_hold = byte_valid && !(enable && byte_ready);
      prev_par  = parallel;
      prev_done = done;
      prev_en   = enable;
    end
  end

  // byte_ready driver: 0 ideal, 1 three stall cycles before each byte, 2 random.
  int sc = 0;
  always @(posedge sd_clock) begin
    #1;
    case (rdy_mode)
      1: begin
        if (!byte_valid) begin byte_ready = 1'b0; sc = 0; end
        else if (sc < 3) begin byte_ready = 1'b0; sc++; end
        else begin byte_ready = 1'b1; sc = 0; end
      end
      2:       byte_ready = ($urandom_range(0, 2) != 0);
      default: byte_ready = 1'b1;
    endcase
  end

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg, output int acc);
    int cnt;
    cnt = 0;
    acc = -1;
    @(posedge sd_clock); #1;
    cmd_valid = 1'b1; cmd_index = idx; cmd_arg = arg;
    while (acc < 0 && cnt < 300) begin
      @(negedge sd_clock);
      if (cmd_ready) begin
        @(posedge sd_clock); #1;
        acc = cyc;
      end
      cnt++;
    end
    cmd_valid = 1'b0;
    chk("cmd_accepted", acc >= 0, 1'b1);
  endtask

  task automatic wait_done(input int bound, output int dc);
    int cnt;
    cnt = 0;
    dc = -1;
    while (dc < 0 && cnt < bound) begin
      @(negedge sd_clock);
      if (done) dc = cyc;
      cnt++;
    end
    chk("done_seen", dc >= 0, 1'b1);
  endtask

  task automatic wait_bv(input int bound, output int bc);
    int cnt;
    cnt = 0;
    bc = -1;
    while (bc < 0 && cnt < bound) begin
      @(negedge sd_clock);
      if (byte_valid) bc = cyc;
      cnt++;
    end
    chk("byte_valid_seen", bc >= 0, 1'b1);
  endtask

  initial begin
    int a, a2, b, d, dn, cnt;
    logic [47:0] f;

    repeat (3) @(posedge sd_clock);
    @(negedge sd_clock);
    chk("rst_parallel", parallel, 8'h00);
    chk("rst_byte_valid", byte_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    @(posedge sd_clock); #1 reset = 1'b0;
    @(negedge sd_clock);
    chk("idle_cmd_ready", cmd_ready, 1'b1);

    // CMD0
    push_bytes(48'h40_00_00_00_00_95);
    issue(6'd0, 32'h0, a);
    @(negedge sd_clock);
    chk("busy_in_crc", busy, 1'b1);
    chk("cmd_ready_low_busy", cmd_ready, 1'b0);
    wait_done(100, d);
    chk("cmd0_done_latency", d - a, 47);
    chk("cmd0_ready_at_done", cmd_ready, 1'b1);
    @(negedge sd_clock);
    chk("cmd0_ready_after", cmd_ready, 1'b1);
    chk("cmd0_idle_busy", busy, 1'b0);

    // CMD8 latency
    push_bytes(48'h48_00_00_01_AA_87);
    issue(6'd8, 32'h0000_01AA, a);
    wait_bv(100, b);
    chk("cmd8_first_valid_latency", b - a, 41);
    wait_done(100, d);
    chk("cmd8_done_latency", d - a, 47);

    // CMD17 with 3-cycle stalls before each byte
    rdy_mode = 1;
    push_bytes(48'h51_00_00_00_00_55);
    issue(6'd17, 32'h0, a);
    wait_done(200, d);
    chk("cmd17_stall_done_latency", d - a, 65);
    rdy_mode = 0;
    repeat (2) @(posedge sd_clock);

    // CMD55 with enable gaps mid-CRC and mid-SEND
    push_bytes(48'h77_00_00_00_00_65);
    issue(6'd55, 32'h0, a);
    repeat (10) @(posedge sd_clock);
    #1 enable = 1'b0;
    repeat (5) @(posedge sd_clock);
    #1 enable = 1'b1;
    wait_bv(100, b);
    chk("cmd55_first_valid_latency", b - a, 46);
    @(posedge sd_clock);
    @(posedge sd_clock);
    #1 enable = 1'b0;
    repeat (5) @(posedge sd_clock);
    #1 enable = 1'b1;
    wait_done(100, d);
    chk("cmd55_done_latency", d - a, 57);

    // reset during byte 2
    push_bytes(48'h40_00_00_00_00_95);
    issue(6'd0, 32'h0, a);
    wait_bv(100, b);
    @(posedge sd_clock);
    @(posedge sd_clock);
    #1 reset = 1'b1;
    #1;
    chk("midrst_parallel", parallel, 8'h00);
    chk("midrst_byte_valid", byte_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    exp_q.delete();
    dn = done_seen;
    repeat (2) @(posedge sd_clock);
    #1 reset = 1'b0;
    @(posedge sd_clock);
    @(negedge sd_clock);
    chk("postrst_cmd_ready", cmd_ready, 1'b1);
    repeat (5) @(negedge sd_clock);
    chk("postrst_no_done", done_seen, dn);
    push_bytes(48'h40_00_00_00_00_95);
    issue(6'd0, 32'h0, a);
    wait_done(100, d);
    chk("postrst_cmd0_done_latency", d - a, 47);

    // cmd_valid held with changing fields during a frame
    push_frame(model_frame(6'd3, 32'hDEAD_BEEF));
    issue(6'd3, 32'hDEAD_BEEF, a);
    cmd_valid = 1'b1;
    a2 = -1;
    cnt = 0;
    while (a2 < 0 && cnt < 200) begin
      @(negedge sd_clock);
      if (cmd_ready) begin
        push_frame(model_frame(cmd_index, cmd_arg));
        @(posedge sd_clock); #1;
        a2 = cyc;
        cmd_valid = 1'b0;
      end else begin
        @(posedge sd_clock); #1;
        cmd_index = 6'($urandom);
        cmd_arg   = $urandom;
      end
      cnt++;
    end
    cmd_valid = 1'b0;
    chk("held_second_accept_gap", a2 - a, 48);
    chk("held_second_after_done", a2 - last_done_cyc, 1);
    wait_done(100, d);
    chk("held_second_done_latency", d - a2, 47);

    // random commands with random byte_ready
    rdy_mode = 2;
    for (int i = 0; i < 10; i++) begin
      logic [5:0]  ri;
      logic [31:0] ra;
      ri = 6'($urandom);
      ra = $urandom;
      f = model_frame(ri, ra);
      push_frame(f);
      issue(ri, ra, a);
      wait_done(400, d);
    end
    rdy_mode = 0;
    repeat (3) @(negedge sd_clock);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cmd_frame_builder.md
CMD_FRAME_BUILDER -- requirements
Module: cmd_frame_builder

Interface
REQ-001 The block SHALL have parameter n, default 8, giving the width of the byte bus to the downstream parallel-to-serial stage.
REQ-002 The block SHALL have port sd_clock, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port enable, input, 1 bit: when low, the block freezes all state and outputs.
REQ-005 The block SHALL have ports cmd_valid (input, 1), cmd_index (input, 6) and cmd_arg (input, 32): the command request from the host controller.
REQ-006 The block SHALL have port cmd_ready, output, 1 bit: the block can accept a command.
REQ-007 The block SHALL have port parallel, output, n bits: the frame byte presented to the parallel-to-serial stage.
REQ-008 The block SHALL have ports byte_valid (output, 1) and byte_ready (input, 1): the byte handshake with the parallel-to-serial stage.
REQ-009 The block SHALL have ports busy (output, 1) and done (output, 1): busy means a frame is in progress; done is a one-cycle pulse at frame completion.

Function
REQ-010 The frame SHALL be 48 bits: bit47 start=0, bit46 transmission=1, [45:40] cmd_index, [39:8] cmd_arg, [7:1] CRC7, bit0 end=1.
REQ-011 CRC7 SHALL use polynomial x^7+x^3+1 with seed 0, computed over frame bits 47..8, MSB first.
REQ-012 The FSM SHALL have states IDLE, CRC, SEND.
REQ-013 cmd_ready SHALL equal (state==IDLE) && enable, combinationally.
REQ-014 In IDLE, when cmd_valid && cmd_ready at an edge, the block SHALL:
- latch the 40-bit header,
- clear the CRC and set bit counter 0,
- enter CRC.
REQ-015 In CRC, the block SHALL shift one header bit per enabled cycle into the CRC for 40 cycles (counter 0..39), then enter SEND with byte counter 0.
REQ-016 In SEND, byte_valid SHALL be 1 and parallel SHALL hold frame byte k (k=0 is bits 47..40, k=5 is {CRC7,1}).
REQ-017 A byte SHALL transfer on an edge where byte_valid && byte_ready; parallel SHALL stay stable until that transfer.
REQ-018 After the transfer of byte 5, the block SHALL:
- return to IDLE,
- drop byte_valid,
- pulse done for exactly one cycle.
REQ-019 With ideal byte_ready, latency from the acceptance edge to the first byte_valid SHALL be 41 cycles, and to done 47 cycles.
REQ-020 busy SHALL be 1 in CRC and SEND and 0 in IDLE.
REQ-021 cmd_valid SHALL be ignored outside IDLE, and the latched fields SHALL NOT change mid-frame.
REQ-022 With enable=0, no state, counter, CRC or output register SHALL change, byte_ready SHALL be ignored, and done SHALL NOT pulse.
REQ-023 Counters SHALL NOT wrap: the bit counter is 6 bits and saturates at the CRC→SEND transition; the byte counter is 3 bits with range 0..5.

Reset
REQ-024 Asserting reset SHALL force state IDLE, with parallel=0, byte_valid=0, busy=0, done=0, and all counters, CRC and latched fields cleared.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no done pulse, and cmd_ready SHALL follow enable from the first edge after release.

Structure
REQ-026 Package sd_cmd_pkg SHALL hold:
- the state enum,
- CRC7 polynomial constant 7'h09,
- frame length 48,
- header length 40,
- byte count 6,
- start/transmission/end bit constants.
REQ-027 CRC7 SHALL be a sub-module crc7_serial (inputs clear, shift_en, data_in; output crc[6:0]), reusable by the response-receive path.

Verification
REQ-028 With cmd_index=0 and cmd_arg=0x00000000 → bytes 40 00 00 00 00 95, then done, cmd_ready high the next cycle.
REQ-029 With cmd_index=8 and cmd_arg=0x000001AA → bytes 48 00 00 01 AA 87, with first byte_valid 41 cycles after acceptance.
REQ-030 With cmd_index=17 and cmd_arg=0, and byte_ready low for 3 cycles before each byte → bytes 51 00 00 00 00 55, parallel stable while stalled, each byte transferred exactly once.
REQ-031 With cmd_index=55 and cmd_arg=0, and enable low for 5 cycles mid-CRC and 5 cycles mid-SEND → bytes 77 00 00 00 00 65, with done delayed by 10 cycles.
REQ-032 With reset pulsed during SEND byte 2, then a new CMD0 request → all outputs 0 immediately, no done, then a clean 40 00 00 00 00 95 frame.
REQ-033 With cmd_valid held high with changing fields during a frame → the second command is accepted only after done, and the first frame's bytes are unaffected.
